// File: rtl/ic651_pkg.sv
// Shared types and helpers for the 74ALS651 transfer controller.
`timescale 1ns/1ps
package ic651_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        TURN    = 3'd1,
        SETUP   = 3'd2,
        PULSE   = 3'd3,
        PRESENT = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic DIR_AB = 1'b0;
    localparam logic DIR_BA = 1'b1;

    // Width of the shared phase counter: enough bits to hold the largest phase length.
    function automatic int unsigned phase_width(input int unsigned a, input int unsigned b,
                                                input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/ic651_xfer_ctrl_if.sv
// Request/acknowledge and transceiver control bundle for the transfer controller.
`timescale 1ns/1ps
interface ic651_xfer_ctrl_if;

    logic ab_req;
    logic ba_req;
    logic ab_ack;
    logic ba_ack;
    logic cpab;
    logic cpba;
    logic sab;
    logic sba;
    logic busy;
    logic dir;

    modport master (
        output ab_req, ba_req,
        input  ab_ack, ba_ack, cpab, cpba, sab, sba, busy, dir
    );

    modport slave (
        input  ab_req, ba_req,
        output ab_ack, ba_ack, cpab, cpba, sab, sba, busy, dir
    );

endinterface

// File: rtl/ic651_xfer_ctrl_phase_timer.sv
// Loadable down-counter that times each controller phase.
`timescale 1ns/1ps
module phase_timer
    import ic651_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    output logic         zero
);

    logic [W-1:0] count;

    // Load on phase entry, then count down and rest at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/ic651_xfer_ctrl.sv
// Arbiter and phase sequencer driving one 74ALS651 transceiver; all outputs registered.
`timescale 1ns/1ps
module ic651_xfer_ctrl
    import ic651_pkg::*;
#(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 2,
    parameter int unsigned HOLD_CYC  = 2,
    parameter int unsigned TURN_CYC  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ic651_xfer_ctrl_if.slave   bus
);

    localparam int unsigned CW = phase_width(SETUP_CYC, PULSE_CYC, HOLD_CYC, TURN_CYC);

    state_t          state;
    state_t          state_nx;
    logic            dir_q;
    logic            dir_nx;
    logic            last_dir;
    logic            load;
    logic [CW-1:0]   load_val;
    logic            zero;

    phase_timer #(.W(CW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .value (load_val),
        .zero  (zero)
    );

    // Next-state and grant decision; ties go opposite to the last served direction.
    always_comb begin
        state_nx = state;
        dir_nx   = dir_q;
        unique case (state)
            IDLE: begin
                if (bus.ab_req || bus.ba_req) begin
                    if (bus.ab_req && bus.ba_req) dir_nx = ~last_dir;
                    else                          dir_nx = bus.ba_req ? DIR_BA : DIR_AB;
                    state_nx = (dir_nx != last_dir) ? TURN : SETUP;
                end
            end
            TURN:    if (zero) state_nx = SETUP;
            SETUP:   if (zero) state_nx = PULSE;
            PULSE:   if (zero) state_nx = PRESENT;
            PRESENT: if (zero) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Phase length reload whenever a new state is entered.
    always_comb begin
        load     = (state_nx != state);
        load_val = '0;
        unique case (state_nx)
            TURN:    load_val = CW'(TURN_CYC - 1);
            SETUP:   load_val = CW'(SETUP_CYC - 1);
            PULSE:   load_val = CW'(PULSE_CYC - 1);
            PRESENT: load_val = CW'(HOLD_CYC - 1);
            default: load_val = '0;
        endcase
    end

    // State, granted direction and last-served direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            dir_q    <= DIR_AB;
            last_dir <= DIR_BA;
        end else begin
            state <= state_nx;
            dir_q <= dir_nx;
            if (state == DONE) last_dir <= dir_q;
        end
    end

    // Outputs decoded from the next state so each pin is a flop that matches the state it reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.cpab   <= 1'b0;
            bus.cpba   <= 1'b0;
            bus.sab    <= 1'b0;
            bus.sba    <= 1'b0;
            bus.ab_ack <= 1'b0;
            bus.ba_ack <= 1'b0;
            bus.busy   <= 1'b0;
        end else begin
            bus.cpab   <= (state_nx == PULSE)   && (dir_nx == DIR_AB);
            bus.cpba   <= (state_nx == PULSE)   && (dir_nx == DIR_BA);
            bus.sab    <= (state_nx == PRESENT) && (dir_nx == DIR_AB);
            bus.sba    <= (state_nx == PRESENT) && (dir_nx == DIR_BA);
            bus.ab_ack <= (state_nx == DONE)    && (dir_nx == DIR_AB);
            bus.ba_ack <= (state_nx == DONE)    && (dir_nx == DIR_BA);
            bus.busy   <= (state_nx != IDLE);
        end
    end

    assign bus.dir = dir_q;

endmodule

// File: doc/ic651_xfer_ctrl.md
# ic651_xfer_ctrl

Sequencer and arbiter for one 74ALS651 registered bus transceiver on the test board. Two requesters share the part: an A-side requester that stores A data and presents it on B, and a B-side requester that stores B data and presents it on A. The block grants one direction at a time and drives cpab/cpba/sab/sba with programmable setup, pulse, hold and turnaround timing. All outputs are registered, so the transceiver clock pins never see a glitch.

## Interface
- SETUP_CYC, default 1: cycles with transparent path (s* = 0) before the capture edge; ≥1
- PULSE_CYC, default 2: cycles the capture clock (cpab/cpba) is held high; ≥1
- HOLD_CYC, default 2: cycles the stored value is presented (s* = 1); ≥1
- TURN_CYC, default 2: idle cycles inserted when direction changes; ≥1

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ab_req  in  1  A→B transfer request, level, held until ab_ack
- ba_req  in  1  B→A transfer request, level, held until ba_ack
- ab_ack  out  1  one-cycle pulse: A→B transfer complete
- ba_ack  out  1  one-cycle pulse: B→A transfer complete
- cpab  out  1  transceiver A→B register clock
- cpba  out  1  transceiver B→A register clock
- sab  out  1  transceiver B-output select (1 = stored A register)
- sba  out  1  transceiver A-output select (1 = stored B register)
- busy  out  1  high whenever state ≠ IDLE
- dir  out  1  direction of the current or last transfer (0 = A→B, 1 = B→A)

## Operation
- States: IDLE → [TURN] → SETUP → PULSE → PRESENT → DONE → IDLE.
- IDLE: samples both requests. If only one is high, grant it. If both are high, grant the direction opposite last_dir (round-robin).
- Grant: latch the direction into dir. If it differs from last_dir, go to TURN; otherwise go to SETUP.
- TURN: hold TURN_CYC cycles with all of cp*/s* at 0.
- SETUP: hold SETUP_CYC cycles with all of cp*/s* at 0.
- PULSE: for PULSE_CYC cycles, the granted clock (cpab for A→B, cpba for B→A) is 1.
- PRESENT: for HOLD_CYC cycles, the granted select (sab or sba) is 1 and the clock is 0.
- DONE: one cycle. The granted ack is 1, all cp*/s* are 0, and last_dir is updated to dir.
- Once granted, a transfer always completes. Dropping the request mid-transfer is ignored.
- A request still high in the cycle after DONE is a new request.
- Only one of cpab/cpba and one of sab/sba may be high at a time. Clock and select are never high together.
- The phase counter is a shared down-counter, width $clog2(max param + 1). It loads N−1 on state entry and advances the state at 0.
- Reset values: state IDLE; all outputs 0; dir 0; last_dir 1 (B→A).
  - Consequently, the first transfer after reset wins a tie for A→B.
  - An A→B first transfer passes through TURN.
- Reset asserted mid-transfer forces every output to 0 immediately.
  - A falling cp* edge is harmless, because the transceiver is rising-edge triggered.
  - The pending ack is lost, and the requester must hold its request to retry.

## Timing
- Grant edge E0 is the first clock edge at which IDLE sees a request.
- Same direction, default parameters:
  - c1 SETUP
  - c2–c3 cp* = 1
  - c4–c5 s* = 1
  - c6 ack = 1
  - earliest next grant at the edge ending c7 (IDLE)
- General same-direction latency from E0 to the ack cycle: SETUP_CYC + PULSE_CYC + HOLD_CYC + 1.
- A direction change adds TURN_CYC to that latency.
- The transceiver register captures at the rising edge of cp*, SETUP_CYC cycles after TURN/grant.
- The capture value is the data on the source port during the SETUP window. Requesters keep source data stable from grant until PULSE ends.
- Back-to-back transfers (ack, IDLE, then the next SETUP) leave at least one IDLE cycle plus one DONE cycle with s* = 0.

## Structure
- Package ic651_pkg holds:
  - state enum (IDLE, TURN, SETUP, PULSE, PRESENT, DONE)
  - DIR_AB = 0, DIR_BA = 1
  - phase-counter width function
- Sub-module phase_timer holds the loadable down-counter.
  - Inputs: load, value.
  - Output: zero.
  - The FSM instantiates it once.
- The top level holds the FSM, arbiter and registered output decode.

## Test plan
- Reset, then ab_req = 1 alone:
  - TURN for 2 cycles, then cpab = 1 for 2 cycles, then sab = 1 for 2 cycles.
  - ab_ack pulse at cycle 8 after grant; transceiver b_o equals the a_i captured.
- Two further ab_req transfers back-to-back: no TURN, ack 6 cycles after each grant, exactly one IDLE cycle between.
- ab_req and ba_req raised together in IDLE (last_dir = A→B):
  - B→A is served first, with TURN.
  - A→B follows, with TURN.
  - Acks arrive in that order.
- ab_req dropped during PULSE: the transfer still completes and ab_ack pulses; no further grant.
- rst_n pulsed low during PRESENT: cp*/s*/acks/busy go to 0 asynchronously. After release, the held request restarts from IDLE with TURN.
- Random requests with SETUP/PULSE/HOLD/TURN = 1/1/1/1 and 3/4/2/3:
  - assertions: cp/s mutual exclusion, ack one-cycle, and latency formula.
